// File: rtl/trng_arbiter_pkg.sv
// Shared types and configuration helpers for the TRNG arbiter.
package trng_pkg;

   typedef enum logic [1:0] {IDLE, FETCH, GAP, DONE} state_t;

   // Words per grant for the default 32-bit result from an 8-bit source
   localparam int PACK = 32 / 8;

   function automatic int pack_of(input int out_w, input int trng_w);
      return out_w / trng_w;
   endfunction

   function automatic bit cfg_ok(input int out_w, input int trng_w, input int timeout);
      return (trng_w > 0) && (out_w % trng_w == 0) && (timeout >= 1);
   endfunction

endpackage

// File: rtl/trng_arbiter_if.sv
// Requester and source-side signals of the TRNG arbiter.
interface trng_arbiter_if #(
   parameter int NREQ       = 2,
   parameter int TRNG_WIDTH = 8,
   parameter int OUT_WIDTH  = 32
);
   logic [NREQ-1:0]       req;
   logic [NREQ-1:0]       ack;
   logic [OUT_WIDTH-1:0]  rdata;
   logic                  err;
   logic                  busy;
   logic [TRNG_WIDTH-1:0] trng_word;
   logic                  trng_valid;
   logic                  trng_req;

   modport slave (
      input  req, trng_word, trng_valid,
      output ack, rdata, err, busy, trng_req
   );

   modport master (
      output req, trng_word, trng_valid,
      input  ack, rdata, err, busy, trng_req
   );
endinterface

// File: rtl/trng_arbiter_rr_arbiter.sv
// Round-robin pick: first set req bit searching upward from last+1.
module rr_arbiter #(
   parameter int NREQ = 2,
   localparam int GW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [GW-1:0]   last,
   output logic [NREQ-1:0] grant,
   output logic [GW-1:0]   grant_idx,
   output logic            any
);
   int p;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      p         = 0;
      for (int k = 1; k <= NREQ; k++) begin
         p = (int'(last) + k) % NREQ;
         if (!any && req[p]) begin
            any       = 1'b1;
            grant[p]  = 1'b1;
            grant_idx = GW'(p);
         end
      end
   end
endmodule

// File: rtl/trng_arbiter.sv
// Shares one TRNG source among NREQ requesters; packs PACK source words per grant.
module trng_arbiter
   import trng_pkg::*;
#(
   parameter int NREQ       = 2,
   parameter int TRNG_WIDTH = 8,
   parameter int OUT_WIDTH  = 32,
   parameter int TIMEOUT    = 1023
) (
   input logic            clk,
   input logic            resetn,
   trng_arbiter_if.slave  bus
);
   localparam int NPACK = pack_of(OUT_WIDTH, TRNG_WIDTH);
   localparam int GW    = $clog2(NREQ);
   localparam int IW    = (NPACK > 1) ? $clog2(NPACK) : 1;
   localparam int CW    = $clog2(TIMEOUT + 1);

   if (!cfg_ok(OUT_WIDTH, TRNG_WIDTH, TIMEOUT)) begin : g_cfg_err
      $error("trng_arbiter: OUT_WIDTH must be a multiple of TRNG_WIDTH and TIMEOUT >= 1");
   end

   state_t               state, state_n;
   logic [GW-1:0]        gnt, gnt_n, last, last_n;
   logic [IW-1:0]        idx, idx_n;
   logic [CW-1:0]        tcnt, tcnt_n;
   logic [OUT_WIDTH-1:0] sreg, sreg_n;
   logic                 errf, errf_n;
   logic                 treq, treq_n;

   logic [NREQ-1:0]      win_oh;
   logic [GW-1:0]        win_idx;
   logic                 win_any;

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .req       (bus.req),
      .last      (last),
      .grant     (win_oh),
      .grant_idx (win_idx),
      .any       (win_any)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= IDLE;
         gnt   <= '0;
         last  <= GW'(NREQ - 1);
         idx   <= '0;
         tcnt  <= '0;
         sreg  <= '0;
         errf  <= 1'b0;
         treq  <= 1'b0;
      end else begin
         state <= state_n;
         gnt   <= gnt_n;
         last  <= last_n;
         idx   <= idx_n;
         tcnt  <= tcnt_n;
         sreg  <= sreg_n;
         errf  <= errf_n;
         treq  <= treq_n;
      end
   end

   // trng_req is the registered image of "next state is FETCH"
   always_comb begin
      state_n = state;
      gnt_n   = gnt;
      last_n  = last;
      idx_n   = idx;
      tcnt_n  = tcnt;
      sreg_n  = sreg;
      errf_n  = errf;
      treq_n  = 1'b0;
      unique case (state)
         IDLE: begin
            if (win_any) begin
               gnt_n   = win_idx;
               idx_n   = '0;
               tcnt_n  = '0;
               sreg_n  = '0;
               errf_n  = 1'b0;
               state_n = FETCH;
               treq_n  = 1'b1;
            end
         end
         FETCH: begin
            if (bus.trng_valid) begin
               sreg_n[int'(idx)*TRNG_WIDTH +: TRNG_WIDTH] = bus.trng_word;
               tcnt_n = '0;
               if (idx == IW'(NPACK - 1)) begin
                  state_n = DONE;
                  last_n  = gnt;
               end else begin
                  idx_n   = idx + IW'(1);
                  state_n = GAP;
               end
            end else if (tcnt == CW'(TIMEOUT - 1)) begin
               errf_n  = 1'b1;
               sreg_n  = '0;
               state_n = DONE;
               last_n  = gnt;
            end else begin
               tcnt_n = tcnt + CW'(1);
               treq_n = 1'b1;
            end
         end
         GAP: begin
            state_n = FETCH;
            treq_n  = 1'b1;
         end
         DONE: begin
            state_n = IDLE;
            errf_n  = 1'b0;
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      bus.ack = '0;
      if (state == DONE) bus.ack[gnt] = 1'b1;
   end

   // sreg is zeroed on timeout, so rdata is 0 on an error completion
   assign bus.rdata    = (state == DONE) ? sreg : '0;
   assign bus.err      = (state == DONE) && errf;
   assign bus.busy     = (state != IDLE);
   assign bus.trng_req = treq;

endmodule

// File: doc/trng_arbiter.md
# trng_arbiter

Shares the single ring-oscillator TRNG source between `NREQ` hardware requesters, such as the CPU MMIO bridge and the pwhash salt generator. It grants requesters round-robin and runs the source's req/valid handshake `PACK = OUT_WIDTH/TRNG_WIDTH` times per grant. The returned words are packed into one `OUT_WIDTH` result. A per-word timeout returns an error instead of hanging the bus if the source stalls.

## Interface

Parameters:
- `NREQ`, default 2: number of requesters, 2..8.
- `TRNG_WIDTH`, default 8: source word width; must divide `OUT_WIDTH`.
- `OUT_WIDTH`, default 32: packed result width.
- `TIMEOUT`, default 1023: maximum cycles to wait for `trng_valid` per word, ≥1.

Ports:
- `clk` in, 1: clock.
- `resetn` in, 1: reset, synchronous, active-low; clock `clk`.
- `req` in, `NREQ`: level request per requester.
- `ack` out, `NREQ`: one-cycle completion pulse, one-hot.
- `rdata` out, `OUT_WIDTH`: packed random value; valid only while any `ack` bit is high, 0 otherwise.
- `err` out, 1: high with `ack` when the grant timed out.
- `busy` out, 1: high in any state other than IDLE.
- `trng_word` in, `TRNG_WIDTH`: source data.
- `trng_valid` in, 1: source data valid.
- `trng_req` out, 1: request to the source, registered.

## Operation

- The FSM states are IDLE, FETCH, GAP and DONE.
- **IDLE**:
  - If any `req` bit is high, latch the round-robin winner as `gnt`.
  - Clear the pack counter `idx`, the timeout counter `tcnt` and the shift register.
  - Go to FETCH and set `trng_req` to 1.
- **FETCH**: `trng_req` is 1.
  - On `trng_valid`, capture `trng_word` into slot `idx`. The first word goes to `rdata[TRNG_WIDTH-1:0]`, LSB-first.
  - Set `trng_req` to 0 and clear `tcnt`.
  - If `idx == PACK-1`, go to DONE; otherwise increment `idx` and go to GAP.
  - If there is no `trng_valid` and `tcnt == TIMEOUT-1`:
    - Set `trng_req` to 0 and set the error flag.
    - Clear the shift register and go to DONE.
  - Otherwise increment `tcnt`.
- **GAP**: exactly one cycle with `trng_req` low, which guarantees the source sees a falling edge. Then go to FETCH with `trng_req` set to 1.
- **DONE**:
  - `ack[gnt]` is 1, `rdata` is the packed value (0 on error), and `err` is the error flag.
  - Go to IDLE and clear the error flag.
- **Round-robin**:
  - The winner is the first set `req` bit searching upward from `(last+1) mod NREQ`.
  - `last` is updated to `gnt` on entry to DONE.
  - After reset `last` is `NREQ-1`, so `req[0]` has highest priority.
- `req` is sampled only in IDLE. A requester must drop `req` in its `ack` cycle; a `req` still high in the following IDLE is treated as a new request.
- Changes to `req` while busy are ignored. A requester deasserting `req` mid-grant still receives its `ack`.
- `trng_valid` outside FETCH is ignored.
- `TRNG_WIDTH == OUT_WIDTH` gives `PACK = 1`: no GAP is visited.

## Timing

- **Reset**: state IDLE; `ack`, `rdata`, `err`, `busy` and `trng_req` are 0; `last` = `NREQ-1`. Reset mid-grant aborts it with no `ack`; `trng_req` is low on the next cycle.
- All outputs are registered or decoded from registered state; there is no combinational path from `req` or `trng_valid` to any output.
- **Latency**: `req` sampled in IDLE at cycle 0 gives `trng_req` high in cycle 1.
- **Best case**: the source asserts `trng_valid` in the first cycle of each FETCH. `ack` then arrives in cycle `2*PACK`, which is cycle 8 for the defaults. Each extra cycle of source delay adds one cycle.
- **Timeout**: with `trng_valid` held low, `ack` and `err` arrive at cycle `TIMEOUT+1` after the last GAP or IDLE.
- **Back-to-back**: from DONE in cycle n, IDLE in n+1 samples the next request, and FETCH follows in n+2. The minimum spacing between grants is therefore `2*PACK+1` cycles.

## Structure

- Shared package `trng_pkg` holds:
  - the state encoding (IDLE, FETCH, GAP, DONE);
  - the localparam `PACK`;
  - the width-check macro/assertion (`OUT_WIDTH % TRNG_WIDTH == 0`, `TIMEOUT ≥ 1`).
- Sub-module `rr_arbiter`, parameterised on `NREQ`: combinational one-hot winner from `req` and `last`. The `last` register stays in `trng_arbiter`.
- The pack shift register, `idx`/`tcnt` counters and FSM live in the top module.

## Test plan

- **Single pack**: `req[0]` only; source returns A5, 3C, 7E, 01 with immediate valid. Require `ack[0]` at cycle 8, `rdata` = 32'h017E3CA5, `err` = 0, and `trng_req` low in each GAP.
- **Round-robin**: `req` = 2'b11 held. Grants must alternate 0, 1, 0, 1; after reset the first grant goes to requester 0.
- **Source stall**: `TIMEOUT` = 16, `trng_valid` never asserted. Require `ack` with `err` = 1 and `rdata` = 0 after 17 cycles, `trng_req` = 0, and the next request served normally.
- **Slow source**: each valid arrives 5 cycles after `trng_req` rises. Require `ack` at cycle 8+4·5 = 28 with correct packing and no timeout.
- **Reset mid-fetch**: reset asserted after 2 words captured. Require no `ack`, all outputs 0 next cycle, and a stale `trng_valid` after reset ignored.
- **Spurious valid**: `trng_valid` pulses while in IDLE and GAP. Require no capture, with data order and `idx` unaffected.
